// File: rtl/decode_stage.sv
// RV32I decode stage: output register plus skid entry, valid/ready both sides.
// Optional RV32M decode enabled by defining DECODE_RV32M_EN.
package common;
  typedef logic [31:0] instruction_type;

  typedef enum logic [2:0] {
    NONE_TYPE, R_TYPE, I_TYPE, S_TYPE,
    B_TYPE, U_TYPE, JAL_TYPE, JALR_TYPE
  } encoding_type;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, B_BNE,
    B_BLT, B_BGE, B_LTU, B_GEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_type;

  typedef struct packed {
    encoding_type encoding;
    alu_op_type   alu_op;
    logic         alu_src;
    logic         mem_read;
    logic         mem_write;
    logic         reg_write;
    logic         mem_to_reg;
    logic         is_branch;
  } control_type;
endpackage

module decode_stage
  import common::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  instruction_type      in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output control_type          out_control,
  output instruction_type      out_instr,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic                 out_illegal,
  output logic                 out_muldiv,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  typedef struct packed {
    control_type           ctl;
    logic                  ill;
    logic                  md;
    instruction_type       instr;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  function automatic alu_op_type alu_rr(
    input logic       alt,
    input logic [2:0] f3
  );
    unique case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  control_type dec_ctl;
  logic dec_ill;
  logic dec_md;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    dec_ctl = '0;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    unique case (op)
      7'b0110011: begin
        dec_ctl.encoding  = R_TYPE;
        dec_ctl.reg_write = 1'b1;
        dec_ctl.alu_op    = alu_rr(f7[5], f3);
        if (f7 == 7'b0100000)
          dec_ill = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          dec_md = 1'b1;
          dec_ctl.alu_op =
            alu_op_type'(5'(ALU_MUL) + 5'(f3));
        end
`endif
        else if (f7 != 7'b0000000)
          dec_ill = 1'b1;
      end
      7'b0010011: begin
        dec_ctl.encoding  = I_TYPE;
        dec_ctl.reg_write = 1'b1;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.alu_op =
          alu_rr((f3 == 3'b101) && f7[5], f3);
        if (f3 == 3'b001)
          dec_ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          dec_ill = (f7 != 7'b0000000) &&
                    (f7 != 7'b0100000);
      end
      7'b0000011: begin
        dec_ctl.encoding   = I_TYPE;
        dec_ctl.reg_write  = 1'b1;
        dec_ctl.alu_src    = 1'b1;
        dec_ctl.mem_read   = 1'b1;
        dec_ctl.mem_to_reg = 1'b1;
        dec_ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      7'b0100011: begin
        dec_ctl.encoding  = S_TYPE;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.mem_write = 1'b1;
        dec_ill = (f3 > 3'b010);
      end
      7'b1100011: begin
        dec_ctl.encoding  = B_TYPE;
        dec_ctl.is_branch = 1'b1;
        unique case (f3)
          3'b000:  dec_ctl.alu_op = ALU_SUB;
          3'b001:  dec_ctl.alu_op = B_BNE;
          3'b100:  dec_ctl.alu_op = B_BLT;
          3'b101:  dec_ctl.alu_op = B_BGE;
          3'b110:  dec_ctl.alu_op = B_LTU;
          3'b111:  dec_ctl.alu_op = B_GEU;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b1100111: begin
        dec_ctl.encoding  = JALR_TYPE;
        dec_ctl.is_branch = 1'b1;
        dec_ctl.reg_write = 1'b1;
        dec_ill = (f3 != 3'b000);
      end
      7'b1101111: dec_ctl.encoding = JAL_TYPE;
      7'b0110111: begin
        dec_ctl.encoding  = U_TYPE;
        dec_ctl.reg_write = 1'b1;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.alu_op    = ALU_LUI;
      end
      7'b0010111: begin
        dec_ctl.encoding  = U_TYPE;
        dec_ctl.reg_write = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_ctl = '0;
      dec_md  = 1'b0;
    end
  end

  entry_t dec_e;
  entry_t out_q;
  entry_t skid_q;
  logic out_vq;
  logic skid_vq;
  logic in_fire;
  logic out_fire;
  logic out_free;

  assign dec_e    = '{ctl: dec_ctl, ill: dec_ill,
                      md: dec_md, instr: in_instr,
                      pc: in_pc};
  assign in_ready = !skid_vq;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_vq && out_ready;
  assign out_free = !out_vq || out_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vq  <= 1'b0;
      skid_vq <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      out_vq  <= 1'b0;
      skid_vq <= 1'b0;
    end else if (out_free) begin
      // skid is always older than anything on the input
      if (skid_vq) begin
        out_q   <= skid_q;
        out_vq  <= 1'b1;
        skid_vq <= 1'b0;
      end else if (in_fire) begin
        out_q  <= dec_e;
        out_vq <= 1'b1;
      end else begin
        out_vq <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q  <= dec_e;
      skid_vq <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      illegal_count <= '0;
    else if (!flush && in_fire && dec_ill &&
             illegal_count != {CNT_WIDTH{1'b1}})
      illegal_count <= illegal_count +
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign out_valid   = out_vq;
  assign out_control = out_q.ctl;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.ill;
`ifdef DECODE_RV32M_EN
  assign out_muldiv  = out_q.md;
`else
  assign out_muldiv  = 1'b0;
  logic unused_md;
  assign unused_md   = out_q.md ^ skid_q.md;
`endif

endmodule
